// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and gate-counter sizing for the divider period monitor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package div_pkg;

  localparam int GATE_CYCLES_DEF = 87;
  localparam int CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Gate counter only ever holds 0..gate_cycles-1.
  function automatic int gate_w(input int gate_cycles);
    return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
  endfunction

endpackage

// File: rtl/div_period_mon_if.sv
// div_period_mon_if: divided-clock input, start request and measurement results.
// Latency: n/a (wiring only).
// Backpressure: none; results are plain level outputs qualified by done.
// master = stimulus/consumer side, slave = monitor side.
interface div_period_mon_if #(
  parameter int CNT_W = 8
);
  logic             div_in;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] min_period;
  logic [CNT_W-1:0] max_period;
  logic             err;

  modport master (
    output div_in, start,
    input  busy, done, edge_cnt, min_period, max_period, err
  );

  modport slave (
    input  div_in, start,
    output busy, done, edge_cnt, min_period, max_period, err
  );
endinterface

// File: rtl/div_edge_timer.sv
// div_edge_timer: registers div_in, flags its rising edges and times the gap between them.
// Latency: rise is the current sample against the registered one; period is valid on the rise cycle.
// Backpressure: none; counts while en=1, held at zero otherwise.
// Ports: clk, rst_n; div_in sample; en count enable; rise pulse; period = clk cycles since previous rise (saturating).
module div_edge_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_in,
  input  logic             en,
  output logic             rise,
  output logic [CNT_W-1:0] period
);

  localparam logic [CNT_W-1:0] SAT = '1;

  logic             div_in_q, div_in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    div_in_d = div_in;
    rise     = div_in & ~div_in_q;
    cnt_d    = cnt_q;
    if (!en || rise) begin
      cnt_d = '0;
    end else if (cnt_q != SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // cnt_q restarts at 0 on the cycle after a rise, so the spacing is cnt_q+1.
    period = (cnt_q == SAT) ? SAT : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_in_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      div_in_q <= div_in_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/div_period_mon.sv
// div_period_mon: counts div_in rising edges over a GATE_CYCLES window and reports min/max rise spacing.
// Latency: done pulses GATE_CYCLES cycles after the arming rise (GATE_CYCLES+1 after start if no rise).
// Backpressure: none; start is only accepted in IDLE, results hold until the next accepted start.
// Ports: clk, rst_n; mon.slave carries div_in/start in and busy/done/edge_cnt/min_period/max_period/err out.
module div_period_mon
  import div_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  div_period_mon_if.slave mon
);

  localparam int               GW        = gate_w(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT       = '1;

  state_e           state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] min_period_q, min_period_d;
  logic [CNT_W-1:0] max_period_q, max_period_d;
  logic             err_q, err_d;

  logic             busy;
  logic             rise;
  logic [CNT_W-1:0] period;

  assign busy = (state_q == ST_ARM) || (state_q == ST_MEAS);

  div_edge_timer #(
    .CNT_W (CNT_W)
  ) u_edge_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_in (mon.div_in),
    .en     (busy),
    .rise   (rise),
    .period (period)
  );

  always_comb begin
    state_d      = state_q;
    gate_d       = gate_q;
    edge_cnt_d   = edge_cnt_q;
    min_period_d = min_period_q;
    max_period_d = max_period_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mon.start) begin
          state_d      = ST_ARM;
          gate_d       = '0;
          edge_cnt_d   = '0;
          min_period_d = SAT;
          max_period_d = '0;
          err_d        = 1'b0;
        end
      end
      ST_ARM: begin
        if (rise) begin
          // The arming rise is window cycle 0, so the next MEAS cycle is 1.
          state_d    = ST_MEAS;
          edge_cnt_d = CNT_W'(1);
          gate_d     = GW'(1);
        end else if (gate_q == GATE_LAST) begin
          state_d      = ST_DONE;
          edge_cnt_d   = '0;
          min_period_d = '0;
          err_d        = 1'b1;
        end else begin
          gate_d = gate_q + GW'(1);
        end
      end
      ST_MEAS: begin
        if (rise) begin
          if (edge_cnt_q != SAT) begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
          if (period < min_period_q) begin
            min_period_d = period;
          end
          if (period > max_period_q) begin
            max_period_d = period;
          end
          if (period == SAT) begin
            err_d = 1'b1;
          end
        end
        if (gate_q == GATE_LAST) begin
          state_d = ST_DONE;
          // A single edge gives no spacing; min would still read its all-ones preset.
          if (edge_cnt_d < CNT_W'(2)) begin
            err_d        = 1'b1;
            min_period_d = '0;
          end
        end else begin
          gate_d = gate_q + GW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gate_q       <= '0;
      edge_cnt_q   <= '0;
      min_period_q <= '0;
      max_period_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_q       <= gate_d;
      edge_cnt_q   <= edge_cnt_d;
      min_period_q <= min_period_d;
      max_period_q <= max_period_d;
      err_q        <= err_d;
    end
  end

  assign mon.busy       = busy;
  assign mon.done       = (state_q == ST_DONE);
  assign mon.edge_cnt   = edge_cnt_q;
  assign mon.min_period = min_period_q;
  assign mon.max_period = max_period_q;
  assign mon.err        = err_q;

endmodule

// File: tb/tb_div_period_mon.sv
// tb_div_period_mon: three monitor instances (87/8, 87/4, 16/8) driven from shared stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_period_mon;

  localparam int NS = 256;

  logic clk, rst_n, div_in, start;
  int   sel;
  int   n_checks = 0;
  int   n_pass   = 0;

  bit   stim     [NS];
  bit   obs_busy [NS];
  int   obs_dp, obs_ndone;
  logic [7:0] obs_edge, obs_min, obs_max, hold_edge, hold_min, hold_max;
  logic obs_err, hold_err;
  bit   hold_seen;
  int   exp_dp, exp_edge, exp_min, exp_max;
  bit   exp_err;

  div_period_mon_if #(.CNT_W(8)) if_a ();
  div_period_mon_if #(.CNT_W(4)) if_b ();
  div_period_mon_if #(.CNT_W(8)) if_c ();

  assign if_a.div_in = div_in;
  assign if_b.div_in = div_in;
  assign if_c.div_in = div_in;
  assign if_a.start  = start && (sel == 0);
  assign if_b.start  = start && (sel == 1);
  assign if_c.start  = start && (sel == 2);

  div_period_mon #(.GATE_CYCLES(87), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .mon(if_a));
  div_period_mon #(.GATE_CYCLES(87), .CNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .mon(if_b));
  div_period_mon #(.GATE_CYCLES(16), .CNT_W(8)) dut_c (.clk(clk), .rst_n(rst_n), .mon(if_c));

  logic       o_busy, o_done, o_err;
  logic [7:0] o_edge, o_min, o_max;

  always_comb begin
    o_busy = if_a.busy; o_done = if_a.done; o_err = if_a.err;
    o_edge = if_a.edge_cnt; o_min = if_a.min_period; o_max = if_a.max_period;
    if (sel == 1) begin
      o_busy = if_b.busy; o_done = if_b.done; o_err = if_b.err;
      o_edge = {4'b0, if_b.edge_cnt}; o_min = {4'b0, if_b.min_period}; o_max = {4'b0, if_b.max_period};
    end else if (sel == 2) begin
      o_busy = if_c.busy; o_done = if_c.done; o_err = if_c.err;
      o_edge = if_c.edge_cnt; o_min = if_c.min_period; o_max = if_c.max_period;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int gate_of(input int s);
    return (s == 2) ? 16 : 87;
  endfunction

  function automatic int width_of(input int s);
    return (s == 1) ? 4 : 8;
  endfunction

  task automatic clear_stim();
    foreach (stim[i]) stim[i] = 1'b0;
  endtask

  task automatic add_rise(input int p, input int w);
    for (int j = 0; j < w; j++) if (p + j < NS) stim[p + j] = 1'b1;
  endtask

  // Reference: find rises in the sampled waveform, take the window from the first
  // rise found within the arming wait, and derive counts and spacings arithmetically.
  task automatic model(input int g, input int w);
    int sat;
    int first;
    int rises[$];
    sat   = (1 << w) - 1;
    first = -1;
    for (int p = 1; p <= g; p++) begin
      if (stim[p] && !stim[p-1]) begin first = p; break; end
    end
    if (first < 0) begin
      exp_dp = g + 1; exp_edge = 0; exp_min = -1; exp_max = 0; exp_err = 1'b1;
      return;
    end
    for (int p = first; p < first + g && p < NS; p++) begin
      if (stim[p] && !stim[p-1]) rises.push_back(p);
    end
    exp_dp   = first + g;
    exp_edge = (rises.size() > sat) ? sat : rises.size();
    exp_err  = 1'b0; exp_min = sat; exp_max = 0;
    for (int i = 1; i < rises.size(); i++) begin
      int d;
      d = rises[i] - rises[i-1];
      if (d >= sat) begin d = sat; exp_err = 1'b1; end
      if (d < exp_min) exp_min = d;
      if (d > exp_max) exp_max = d;
    end
    if (rises.size() < 2) begin exp_err = 1'b1; exp_min = 0; end
  endtask

  // Period p: stim[p] is driven during it; outputs seen at its negedge reflect edges up to p-1.
  task automatic drive_meas(input int s, input int n_per, input int pulse_p);
    sel = s; obs_dp = -1; obs_ndone = 0; hold_seen = 1'b0;
    obs_edge = '0; obs_min = '0; obs_max = '0; obs_err = 1'b0;
    foreach (obs_busy[i]) obs_busy[i] = 1'b0;
    @(negedge clk); start = 1'b0; div_in = 1'b0;
    @(negedge clk); start = 1'b1; div_in = stim[0];
    for (int p = 1; p < n_per && p < NS; p++) begin
      @(negedge clk);
      obs_busy[p] = o_busy;
      if (o_done) begin
        obs_ndone++;
        if (obs_dp < 0) begin
          obs_dp = p; obs_edge = o_edge; obs_min = o_min; obs_max = o_max; obs_err = o_err;
        end
      end
      if (obs_dp >= 0 && p == obs_dp + 4) begin
        hold_seen = 1'b1; hold_edge = o_edge; hold_min = o_min; hold_max = o_max; hold_err = o_err;
      end
      start  = (p == pulse_p);
      div_in = stim[p];
    end
    start = 1'b0; div_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; div_in = 1'b0; start = 1'b0; sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_checks++;
      if ({o_busy, o_done, o_edge, o_min, o_max, o_err} !== 27'b0)
        $display("FAIL reset_outputs inst%0d: got %h want 0", s, {o_busy, o_done, o_edge, o_min, o_max, o_err});
      else n_pass++;
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_pattern87();
    int p, k;
    clear_stim(); p = 5; k = 0;
    while (p < NS) begin
      add_rise(p, 4); p += (k % 10 < 3) ? 8 : 9; k++;
    end
    model(87, 8);
    drive_meas(0, exp_dp + 6, -1);
    n_checks++; if (obs_dp !== exp_dp) $display("FAIL pat87 done_cycle: got %0d want %0d", obs_dp, exp_dp); else n_pass++;
    n_checks++; if (obs_edge !== 8'(exp_edge)) $display("FAIL pat87 edge_cnt: got %0d want %0d", obs_edge, exp_edge); else n_pass++;
    n_checks++; if (obs_min !== 8'(exp_min)) $display("FAIL pat87 min_period: got %0d want %0d", obs_min, exp_min); else n_pass++;
    n_checks++; if (obs_max !== 8'(exp_max)) $display("FAIL pat87 max_period: got %0d want %0d", obs_max, exp_max); else n_pass++;
    n_checks++; if (obs_err !== exp_err) $display("FAIL pat87 err: got %0b want %0b", obs_err, exp_err); else n_pass++;
    n_checks++;
    if (!hold_seen || hold_edge !== 8'(exp_edge) || hold_min !== 8'(exp_min) || hold_max !== 8'(exp_max) || hold_err !== exp_err)
      $display("FAIL pat87 hold: got seen=%0b %0d/%0d/%0d/%0b want %0d/%0d/%0d/%0b",
               hold_seen, hold_edge, hold_min, hold_max, hold_err, exp_edge, exp_min, exp_max, exp_err);
    else n_pass++;
  endtask

  task automatic test_no_edge();
    int bad;
    clear_stim(); model(87, 8);
    drive_meas(0, exp_dp + 6, -1);
    bad = 0;
    for (int p = 1; p <= exp_dp; p++) if (obs_busy[p] !== (p < exp_dp)) bad++;
    n_checks++; if (obs_dp !== exp_dp) $display("FAIL noedge done_cycle: got %0d want %0d", obs_dp, exp_dp); else n_pass++;
    n_checks++; if (obs_err !== exp_err) $display("FAIL noedge err: got %0b want %0b", obs_err, exp_err); else n_pass++;
    n_checks++; if (obs_edge !== 8'(exp_edge)) $display("FAIL noedge edge_cnt: got %0d want %0d", obs_edge, exp_edge); else n_pass++;
    n_checks++; if (obs_max !== 8'(exp_max)) $display("FAIL noedge max_period: got %0d want %0d", obs_max, exp_max); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL noedge busy: got %0d wrong cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_single_rise();
    clear_stim(); add_rise(30, 3); model(87, 8);
    drive_meas(0, exp_dp + 6, -1);
    n_checks++; if (obs_dp !== exp_dp) $display("FAIL single done_cycle: got %0d want %0d", obs_dp, exp_dp); else n_pass++;
    n_checks++; if (obs_edge !== 8'(exp_edge)) $display("FAIL single edge_cnt: got %0d want %0d", obs_edge, exp_edge); else n_pass++;
    n_checks++; if (obs_err !== exp_err) $display("FAIL single err: got %0b want %0b", obs_err, exp_err); else n_pass++;
    n_checks++; if (obs_min !== 8'(exp_min)) $display("FAIL single min_period: got %0d want %0d", obs_min, exp_min); else n_pass++;
  endtask

  task automatic test_saturate();
    clear_stim();
    for (int p = 3; p < NS; p += 20) add_rise(p, 5);
    model(87, 4);
    drive_meas(1, exp_dp + 6, -1);
    n_checks++; if (obs_max !== 8'(exp_max)) $display("FAIL sat max_period: got %0d want %0d", obs_max, exp_max); else n_pass++;
    n_checks++; if (obs_err !== exp_err) $display("FAIL sat err: got %0b want %0b", obs_err, exp_err); else n_pass++;
    n_checks++; if (obs_edge !== 8'(exp_edge)) $display("FAIL sat edge_cnt: got %0d want %0d", obs_edge, exp_edge); else n_pass++;
  endtask

  task automatic test_square();
    clear_stim();
    for (int p = 2; p < NS; p += 4) add_rise(p, 2);
    model(16, 8);
    drive_meas(2, exp_dp + 6, -1);
    n_checks++; if (obs_dp !== exp_dp) $display("FAIL square done_cycle: got %0d want %0d", obs_dp, exp_dp); else n_pass++;
    n_checks++; if (obs_edge !== 8'(exp_edge)) $display("FAIL square edge_cnt: got %0d want %0d", obs_edge, exp_edge); else n_pass++;
    n_checks++;
    if (obs_min !== 8'(exp_min) || obs_max !== 8'(exp_max))
      $display("FAIL square min/max: got %0d/%0d want %0d/%0d", obs_min, obs_max, exp_min, exp_max);
    else n_pass++;
    n_checks++; if (obs_err !== exp_err) $display("FAIL square err: got %0b want %0b", obs_err, exp_err); else n_pass++;
  endtask

  task automatic test_start_ignored();
    clear_stim();
    for (int p = 4; p < NS; p += 7) add_rise(p, 3);
    model(87, 8);
    drive_meas(0, exp_dp + 6, exp_dp - 20);
    n_checks++; if (obs_ndone !== 1) $display("FAIL start_meas done_count: got %0d want 1", obs_ndone); else n_pass++;
    n_checks++; if (obs_dp !== exp_dp) $display("FAIL start_meas done_cycle: got %0d want %0d", obs_dp, exp_dp); else n_pass++;
    n_checks++; if (obs_edge !== 8'(exp_edge)) $display("FAIL start_meas edge_cnt: got %0d want %0d", obs_edge, exp_edge); else n_pass++;
    drive_meas(0, exp_dp + 6, exp_dp);
    n_checks++;
    if (obs_ndone !== 1 || obs_busy[exp_dp + 1] !== 1'b0)
      $display("FAIL start_done ignored: got done_count=%0d busy=%0b want 1/0", obs_ndone, obs_busy[exp_dp + 1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    clear_stim();
    for (int p = 3; p < NS; p += 7) add_rise(p, 3);
    drive_meas(0, 40, -1);
    @(negedge clk); rst_n = 1'b0; #1;
    n_checks++;
    if ({o_busy, o_done, o_edge, o_min, o_max, o_err} !== 27'b0 || obs_ndone !== 0)
      $display("FAIL reset_mid outputs: got %h done_count=%0d want 0/0", {o_busy, o_done, o_edge, o_min, o_max, o_err}, obs_ndone);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; bad = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk); div_in = stim[i];
      if (o_done !== 1'b0 || o_busy !== 1'b0) bad++;
    end
    div_in = 1'b0;
    n_checks++; if (bad !== 0) $display("FAIL reset_mid no_done: got %0d active cycles want 0", bad); else n_pass++;
    model(87, 8);
    drive_meas(0, exp_dp + 6, -1);
    n_checks++;
    if (obs_dp !== exp_dp || obs_edge !== 8'(exp_edge) || obs_err !== exp_err)
      $display("FAIL reset_mid fresh: got %0d/%0d/%0b want %0d/%0d/%0b", obs_dp, obs_edge, obs_err, exp_dp, exp_edge, exp_err);
    else n_pass++;
  endtask

  task automatic test_random();
    int s, g, p, gap;
    for (int it = 0; it < 8; it++) begin
      s = $urandom_range(0, 2); g = gate_of(s);
      clear_stim();
      p = $urandom_range(1, g + 5);
      while (p < NS) begin
        gap = $urandom_range(2, 24);
        add_rise(p, $urandom_range(1, gap - 1));
        p += gap;
      end
      model(g, width_of(s));
      drive_meas(s, exp_dp + 6, -1);
      n_checks++; if (obs_dp !== exp_dp) $display("FAIL rnd%0d done_cycle: got %0d want %0d", it, obs_dp, exp_dp); else n_pass++;
      n_checks++; if (obs_edge !== 8'(exp_edge)) $display("FAIL rnd%0d edge_cnt: got %0d want %0d", it, obs_edge, exp_edge); else n_pass++;
      n_checks++; if (obs_max !== 8'(exp_max)) $display("FAIL rnd%0d max_period: got %0d want %0d", it, obs_max, exp_max); else n_pass++;
      n_checks++; if (obs_err !== exp_err) $display("FAIL rnd%0d err: got %0b want %0b", it, obs_err, exp_err); else n_pass++;
      if (exp_min >= 0) begin
        n_checks++; if (obs_min !== 8'(exp_min)) $display("FAIL rnd%0d min_period: got %0d want %0d", it, obs_min, exp_min); else n_pass++;
      end
      n_checks++; if (obs_ndone !== 1) $display("FAIL rnd%0d done_count: got %0d want 1", it, obs_ndone); else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; div_in = 1'b0; start = 1'b0; sel = 0;
    test_reset();
    test_pattern87();
    test_no_edge();
    test_single_rise();
    test_saturate();
    test_square();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_period_mon.md
DIV_PERIOD_MON -- requirements
Module: div_period_mon

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 87, measurement window length in clk cycles (>=2).
REQ-002 SHALL have parameter CNT_W, default 8, width of the count and period result fields.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port div_in  input  1  divided clock from the upstream divider, synchronous to clk.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a measurement.
REQ-007 SHALL have port busy  output  1  high while a measurement is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results are valid.
REQ-009 SHALL have port edge_cnt  output  CNT_W  count of div_in rising edges in the window.
REQ-010 SHALL have port min_period  output  CNT_W  smallest rise-to-rise spacing in clk cycles.
REQ-011 SHALL have port max_period  output  CNT_W  largest rise-to-rise spacing in clk cycles.
REQ-012 SHALL have port err  output  1  result invalid: fewer than two edges, or a period saturated.

Function
REQ-013 SHALL register div_in once; a rise is div_in=1 with the registered copy=0.
REQ-014 SHALL implement FSM states IDLE, ARM, MEAS, DONE.
REQ-015 IDLE: on start=1, SHALL go to ARM and clear edge_cnt, max_period and err; min_period is preset to all-ones.
REQ-016 ARM: on rise, SHALL go to MEAS, set edge_cnt=1, zero the period counter and load the gate counter.
REQ-017 ARM: if no rise within GATE_CYCLES cycles, SHALL go to DONE with err=1 and edge_cnt=0.
REQ-018 MEAS: the window is GATE_CYCLES cycles long, counting the arming rise as cycle 0; each rise inside it SHALL increment edge_cnt (saturating) and update min/max with the current period, then reset the period counter.
REQ-019 Period value is the cycle distance between rises: rises k cycles apart SHALL record k.
REQ-020 The period counter SHALL saturate at 2^CNT_W-1; if a saturated value is recorded, err SHALL be set.
REQ-021 At the end of the window, SHALL go to DONE; err SHALL be set if edge_cnt<2, and min_period SHALL then read 0.
REQ-022 DONE SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in ARM and MEAS and 0 in IDLE and DONE.
REQ-024 start SHALL be ignored when busy=1 or in DONE.
REQ-025 Results SHALL hold stable from done until the next accepted start.

Reset
REQ-026 On rst_n=0, SHALL set state=IDLE, busy=0, done=0, edge_cnt=0, min_period=0, max_period=0, err=0, and clear all counters and the div_in register.
REQ-027 A reset mid-measurement SHALL abort with no done pulse; the first start after release begins a fresh measurement.

Structure
REQ-028 The FSM state encoding and GATE_CYCLES-derived counter widths ($clog2) SHALL be in shared package div_pkg.
REQ-029 The rise detector plus period counter SHALL be sub-module div_edge_timer; everything else stays flat.

Verification
REQ-030 Upstream 87-cycle pattern (3 periods of 8, then 7 of 9), GATE_CYCLES=87, start -> done with edge_cnt=10, min=8, max=9, err=0.
REQ-031 div_in held 0, start -> done exactly 88 cycles after start, err=1, edge_cnt=0.
REQ-032 Single rise only within window -> edge_cnt=1, err=1, min_period=0.
REQ-033 CNT_W=4, rises 20 cycles apart -> max_period=15, err=1.
REQ-034 start pulsed during MEAS -> ignored, one done only; rst_n low mid-MEAS -> all outputs 0, no done.
REQ-035 div_in square wave period 4, GATE_CYCLES=16 -> edge_cnt=4, min=max=4, err=0.
